rob_commit: RTL and testbench
=============================

Name: rob_commit

Overview:
- 8-entry reorder buffer that receives results from the WB stage register and retires them in program order to the register file.
- At issue, the block allocates an entry and returns its index. That index travels down the pipe as tail_rob.
- At writeback, the WB stage outputs (result, destReg, we, bp, tail_rob) mark the entry complete.
- The head entry commits one per cycle, issues a register-file write, and flushes younger entries on a mispredict or exception.

Parameters:
- ENTRIES, 8, number of ROB entries (power of 2)
- IDX_W, 3, entry index width (log2 ENTRIES)
- DATA_W, 16, result width
- RADDR_W, 3, register address width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- alloc_req  in  1  issue requests an entry
- alloc_destReg  in  RADDR_W  destination register of the issuing instruction
- alloc_we  in  1  issuing instruction writes a register
- alloc_grant  out  1  combinational; allocation accepted this cycle
- alloc_tail  out  IDX_W  index given to the accepted instruction (current tail)
- wb_valid  in  1  WB stage output valid
- wb_result  in  DATA_W  result from WB stage
- wb_destReg  in  RADDR_W  destination register from WB stage
- wb_we  in  1  write enable from WB stage
- wb_bp  in  2  status: 00 normal, 01 mispredict, 10 exception, 11 reserved (treated as exception)
- wb_tail_rob  in  IDX_W  target entry index
- commit_valid  out  1  registered; one instruction retired
- rf_we  out  1  registered; register-file write strobe
- rf_addr  out  RADDR_W  registered; register-file write address
- rf_data  out  DATA_W  registered; register-file write data
- flush  out  1  registered; pipeline flush pulse
- full  out  1  registered-state; count == ENTRIES
- empty  out  1  registered-state; count == 0

Behaviour:
- State:
  - per-entry valid, done, we, destReg, data, bp
  - head and tail pointers (IDX_W bits, wrap modulo ENTRIES)
  - count (IDX_W+1 bits)
- Reset (reset==0 at a clk edge):
  - all valid and done bits cleared
  - head=tail=count=0
  - all registered outputs 0; empty=1, full=0
- Allocation:
  - alloc_grant = alloc_req & !full & !head_flush.
  - head_flush = valid[head] & done[head] & bp[head]!=00.
  - On grant: entry[tail] gets valid=1, done=0, we=alloc_we, destReg=alloc_destReg; tail increments.
  - alloc_tail always shows the current tail.
- Writeback:
  - Applies when wb_valid=1, valid[wb_tail_rob]=1 and done[wb_tail_rob]=0.
  - Sets done=1 and stores data=wb_result, bp=wb_bp.
  - we is updated to wb_we and destReg to wb_destReg; the WB-stage values take precedence.
  - A writeback to an invalid or already-done entry is silently dropped.
- Commit:
  - Condition: valid[head] & done[head].
  - head_ready is evaluated on registered state only. A writeback to the head entry in cycle N can commit at the earliest in cycle N+1; its outputs appear after the N+1 edge.
  - On commit:
    - commit_valid=1, rf_addr=destReg, rf_data=data
    - rf_we = we & (bp != 1x); exceptions suppress the write
    - valid[head] cleared; head increments
  - At most one commit per cycle. With no commit, all registered outputs return to 0 the next cycle.
- Flush (committing entry has bp != 00):
  - flush=1 together with commit_valid.
  - All valid bits are cleared; tail and head both become old head+1; count=0.
  - A simultaneous writeback in that cycle is dropped.
  - Allocation is blocked in that cycle through alloc_grant.
- Counting: count += grant - commit. A simultaneous allocate and commit leaves count unchanged.
- Full: alloc_grant=0 even if a commit frees an entry in the same cycle; the decision is conservative and uses registered full.
- Wrap-around: pointers wrap from 7 to 0 naturally; entry indices stay stable while an instruction is in flight.
- Reset mid-operation: all entries are discarded. Any pending commit outputs are zero on the next cycle.

Decomposition:
- Package rob_pkg holds:
  - ENTRIES, IDX_W, DATA_W, RADDR_W
  - bp encodings BP_NORMAL=2'b00, BP_MISPRED=2'b01, BP_EXC=2'b10
  - the rob entry field widths
- Commit outputs {commit_valid, rf_we, rf_addr, rf_data, flush}, 22 bits total, are held in the team's existing parameterised register module (register #(22)). Its enable is tied high, and its reset is driven from the active-low synchronous reset.
- Entry array, pointers and control live in rob_commit itself.

Test Plan:
- Reset sequence:
  - Stimulus: hold reset=0 for 2 cycles, then release.
  - Required: empty=1, full=0, commit_valid=0, rf_we=0, flush=0, alloc_tail=0.
- Out-of-order writeback:
  - Stimulus: allocate 3 entries with dest r1, r2, r3 (we=1). Write back tail 2 (data 0x0033), then tail 0 (data 0x0011), then tail 1 (data 0x0022).
  - Required: commits in order r1=0x0011, r2=0x0022, r3=0x0033, one per cycle. Nothing commits before tail 0 completes.
- Full and wrap:
  - Stimulus: allocate 8 entries, then a 9th request.
  - Required: full=1 and alloc_grant=0 for the 9th. After one commit, the next allocate is granted with alloc_tail=0 (wrap).
- Mispredict flush:
  - Stimulus: allocate 4 entries, all done. Entry 1 has bp=01.
  - Required: entry 0 commits. Entry 1 commits with rf_we=1 and flush=1 in the same cycle. Entries 2–3 never commit. Afterwards empty=1 and alloc_tail=2.
- Exception suppression:
  - Stimulus: entry with we=1 and bp=10 reaches head.
  - Required: commit_valid=1, rf_we=0, flush=1.
- Illegal writebacks and mid-operation reset:
  - Stimulus: writeback to an unallocated index; a second writeback to a done entry with different data; assert reset with 5 entries pending.
  - Required: the first two are ignored and the original data commits. After reset: count=0 and no commits follow.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared widths, branch/exception status encodings and entry layouts for the
// reorder buffer and its commit path.
package rob_pkg;

    localparam int ENTRIES  = 8;
    localparam int IDX_W    = 3;
    localparam int DATA_W   = 16;
    localparam int RADDR_W  = 3;
    localparam int CNT_W    = IDX_W + 1;

    localparam logic [1:0] BP_NORMAL  = 2'b00;
    localparam logic [1:0] BP_MISPRED = 2'b01;
    localparam logic [1:0] BP_EXC     = 2'b10;

    // Payload of one ROB slot; valid/done live in separate vectors so they can be reset.
    typedef struct packed {
        logic               we;
        logic [RADDR_W-1:0] dest;
        logic [DATA_W-1:0]  data;
        logic [1:0]         bp;
    } rob_entry_t;

    typedef struct packed {
        logic               commit_valid;
        logic               rf_we;
        logic [RADDR_W-1:0] rf_addr;
        logic [DATA_W-1:0]  rf_data;
        logic               flush;
    } commit_t;

    localparam int COMMIT_W = $bits(commit_t);

    // The reserved encoding 2'b11 behaves as an exception.
    function automatic logic bp_is_exc(input logic [1:0] bp);
        logic is_exc;
        case (bp)
            BP_NORMAL, BP_MISPRED: is_exc = 1'b0;
            BP_EXC:                is_exc = 1'b1;
            default:               is_exc = 1'b1;
        endcase
        return is_exc;
    endfunction

endpackage

// File: rtl/register.sv
// Generic enable register with synchronous active-low clear.
module register #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/rob_commit.sv
// 8-entry reorder buffer: allocates at issue, completes at writeback, retires
// in order to the register file and flushes younger work on mispredict/exception.
module rob_commit
    import rob_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               alloc_req,
    input  logic [RADDR_W-1:0] alloc_destReg,
    input  logic               alloc_we,
    output logic               alloc_grant,
    output logic [IDX_W-1:0]   alloc_tail,
    input  logic               wb_valid,
    input  logic [DATA_W-1:0]  wb_result,
    input  logic [RADDR_W-1:0] wb_destReg,
    input  logic               wb_we,
    input  logic [1:0]         wb_bp,
    input  logic [IDX_W-1:0]   wb_tail_rob,
    output logic               commit_valid,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0]  rf_data,
    output logic               flush,
    output logic               full,
    output logic               empty
);

    rob_entry_t         ent_q [ENTRIES];
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [ENTRIES-1:0] done_q, done_d;
    logic [IDX_W-1:0]   head_q, head_d;
    logic [IDX_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               head_ready, head_flush, wb_hit;
    commit_t            commit_d, commit_q;

    assign full        = (count_q == CNT_W'(ENTRIES));
    assign empty       = (count_q == '0);
    assign head_ready  = valid_q[head_q] & done_q[head_q];
    assign head_flush  = head_ready & (ent_q[head_q].bp != BP_NORMAL);
    assign alloc_grant = alloc_req & ~full & ~head_flush;
    assign alloc_tail  = tail_q;
    assign wb_hit      = wb_valid & valid_q[wb_tail_rob] & ~done_q[wb_tail_rob] & ~head_flush;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        valid_d  = valid_q;
        done_d   = done_q;
        head_d   = head_q;
        tail_d   = tail_q;
        commit_d = '0;

        if (wb_hit) begin
            done_d[wb_tail_rob] = 1'b1;
        end

        if (head_ready) begin
            commit_d.commit_valid = 1'b1;
            commit_d.rf_we        = ent_q[head_q].we & ~bp_is_exc(ent_q[head_q].bp);
            commit_d.rf_addr      = ent_q[head_q].dest;
            commit_d.rf_data      = ent_q[head_q].data;
            commit_d.flush        = head_flush;
            valid_d[head_q]       = 1'b0;
            done_d[head_q]        = 1'b0;
            head_d                = head_q + IDX_W'(1);
        end

        if (alloc_grant) begin
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
            tail_d          = tail_q + IDX_W'(1);
        end

        count_d = count_q + CNT_W'(alloc_grant) - CNT_W'(head_ready);

        // A flushing commit discards everything younger and restarts just past itself.
        if (head_flush) begin
            valid_d = '0;
            done_d  = '0;
            head_d  = head_q + IDX_W'(1);
            tail_d  = head_q + IDX_W'(1);
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: the payload array has no reset; valid/done gate every read of it.
    always_ff @(posedge clk) begin
        if (alloc_grant) begin
            ent_q[tail_q].we   <= alloc_we;
            ent_q[tail_q].dest <= alloc_destReg;
        end
        if (wb_hit) begin
            ent_q[wb_tail_rob] <= '{we: wb_we, dest: wb_destReg, data: wb_result, bp: wb_bp};
        end
    end

    register #(.WIDTH(COMMIT_W)) u_commit_reg (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .d     (commit_d),
        .q     (commit_q)
    );

    assign commit_valid = commit_q.commit_valid;
    assign rf_we        = commit_q.rf_we;
    assign rf_addr      = commit_q.rf_addr;
    assign rf_data      = commit_q.rf_data;
    assign flush        = commit_q.flush;

endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: directed scenarios plus random traffic, all checked
// against an in-order queue model of the reorder buffer.
module tb_rob_commit;
    import rob_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               alloc_req, alloc_we, alloc_grant;
    logic [RADDR_W-1:0] alloc_destReg;
    logic [IDX_W-1:0]   alloc_tail;
    logic               wb_valid, wb_we;
    logic [DATA_W-1:0]  wb_result;
    logic [RADDR_W-1:0] wb_destReg;
    logic [1:0]         wb_bp;
    logic [IDX_W-1:0]   wb_tail_rob;
    logic               commit_valid, rf_we, flush, full, empty;
    logic [RADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0]  rf_data;

    rob_commit dut (
        .clk           (clk),
        .reset         (reset),
        .alloc_req     (alloc_req),
        .alloc_destReg (alloc_destReg),
        .alloc_we      (alloc_we),
        .alloc_grant   (alloc_grant),
        .alloc_tail    (alloc_tail),
        .wb_valid      (wb_valid),
        .wb_result     (wb_result),
        .wb_destReg    (wb_destReg),
        .wb_we         (wb_we),
        .wb_bp         (wb_bp),
        .wb_tail_rob   (wb_tail_rob),
        .commit_valid  (commit_valid),
        .rf_we         (rf_we),
        .rf_addr       (rf_addr),
        .rf_data       (rf_data),
        .flush         (flush),
        .full          (full),
        .empty         (empty)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: the in-flight instructions in program order, oldest first.
    typedef struct {
        logic [2:0]  idx;
        logic [2:0]  dest;
        logic        we;
        logic        done;
        logic [15:0] data;
        logic [1:0]  bp;
    } ment_t;
    ment_t mq[$];
    int    m_head = 0;
    int    m_tail = 0;
    logic        e_cv, e_we, e_fl;
    logic [2:0]  e_addr;
    logic [15:0] e_data;

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] data;
        logic        we;
        logic        fl;
    } cm_t;
    cm_t clog[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step(output bit g, output int t_before);
        bit hr, hf;
        t_before = m_tail;
        g = 1'b0;
        e_cv = 1'b0; e_we = 1'b0; e_fl = 1'b0; e_addr = '0; e_data = '0;
        if (!reset) begin
            mq.delete();
            m_head = 0;
            m_tail = 0;
            return;
        end
        hr = (mq.size() > 0) && mq[0].done;
        hf = hr && (mq[0].bp != BP_NORMAL);
        g  = alloc_req && (mq.size() < ENTRIES) && !hf;
        if (wb_valid && !hf) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (mq[i].idx == wb_tail_rob && !mq[i].done) begin
                    mq[i].done = 1'b1;
                    mq[i].data = wb_result;
                    mq[i].bp   = wb_bp;
                    mq[i].we   = wb_we;
                    mq[i].dest = wb_destReg;
                end
            end
        end
        if (hr) begin
            e_cv   = 1'b1;
            e_we   = mq[0].we && !(mq[0].bp inside {2'b10, 2'b11});
            e_addr = mq[0].dest;
            e_data = mq[0].data;
            e_fl   = hf;
            void'(mq.pop_front());
            m_head = (m_head + 1) % ENTRIES;
            if (hf) begin
                mq.delete();
                m_tail = m_head;
            end
        end
        if (g) begin
            mq.push_back('{idx: 3'(m_tail), dest: alloc_destReg, we: alloc_we,
                           done: 1'b0, data: 16'h0, bp: 2'b00});
            m_tail = (m_tail + 1) % ENTRIES;
        end
    endtask

    task automatic cycle(input bit pre);
        bit g;
        int t;
        #1;
        model_step(g, t);
        if (pre) begin
            chk("alloc_grant", alloc_grant, g);
            chk("alloc_tail", alloc_tail, t);
        end
        @(posedge clk);
        #1;
        chk("commit_valid", commit_valid, e_cv);
        chk("rf_we", rf_we, e_we);
        chk("rf_addr", rf_addr, e_addr);
        chk("rf_data", rf_data, e_data);
        chk("flush", flush, e_fl);
        chk("full", full, mq.size() == ENTRIES);
        chk("empty", empty, mq.size() == 0);
        if (commit_valid === 1'b1) clog.push_back('{addr: rf_addr, data: rf_data, we: rf_we, fl: flush});
    endtask

    task automatic set_idle();
        alloc_req = 0; alloc_destReg = '0; alloc_we = 0;
        wb_valid = 0; wb_result = '0; wb_destReg = '0; wb_we = 0; wb_bp = '0; wb_tail_rob = '0;
    endtask

    task automatic do_idle(input int n);
        repeat (n) begin
            set_idle();
            cycle(1);
        end
    endtask

    task automatic do_alloc(input logic [2:0] d, input logic we);
        set_idle();
        alloc_req = 1; alloc_destReg = d; alloc_we = we;
        cycle(1);
    endtask

    task automatic do_wb(input logic [2:0] idx, input logic [15:0] data, input logic [2:0] d,
                         input logic we, input logic [1:0] bp);
        set_idle();
        wb_valid = 1; wb_tail_rob = idx; wb_result = data; wb_destReg = d; wb_we = we; wb_bp = bp;
        cycle(1);
    endtask

    task automatic do_reset();
        set_idle();
        reset = 0;
        cycle(1);
        cycle(1);
        reset = 1;
    endtask

    function automatic cm_t log_at(input int i);
        cm_t none = '{addr: 'x, data: 'x, we: 'x, fl: 'x};
        return (i < clog.size()) ? clog[i] : none;
    endfunction

    initial begin
        set_idle();
        reset = 0;
        cycle(0);
        cycle(0);
        reset = 1;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_cv", commit_valid, 0);
        chk("rst_flush", flush, 0);
        chk("rst_tail", alloc_tail, 0);

        // Out-of-order completion retires in program order.
        clog.delete();
        do_alloc(3'd1, 1); do_alloc(3'd2, 1); do_alloc(3'd3, 1);
        do_wb(3'd2, 16'h0033, 3'd3, 1, BP_NORMAL);
        do_wb(3'd0, 16'h0011, 3'd1, 1, BP_NORMAL);
        chk("ooo_early", clog.size(), 0);
        do_wb(3'd1, 16'h0022, 3'd2, 1, BP_NORMAL);
        do_idle(4);
        chk("ooo_count", clog.size(), 3);
        chk("ooo_addr0", log_at(0).addr, 1); chk("ooo_data0", log_at(0).data, 16'h0011);
        chk("ooo_addr1", log_at(1).addr, 2); chk("ooo_data1", log_at(1).data, 16'h0022);
        chk("ooo_addr2", log_at(2).addr, 3); chk("ooo_data2", log_at(2).data, 16'h0033);

        // Full, conservative grant, and tail wrap.
        do_reset();
        for (int i = 0; i < 8; i++) do_alloc(3'(i), 1);
        chk("full_set", full, 1);
        set_idle(); alloc_req = 1; alloc_destReg = 3'd5;
        #1 chk("full_9th_grant", alloc_grant, 0);
        cycle(1);
        do_wb(3'd0, 16'h00A0, 3'd0, 1, BP_NORMAL);
        set_idle(); alloc_req = 1; alloc_destReg = 3'd5;
        #1 chk("full_conservative", alloc_grant, 0);
        cycle(1);
        set_idle(); alloc_req = 1; alloc_destReg = 3'd6; alloc_we = 1;
        #1 chk("wrap_grant", alloc_grant, 1);
        chk("wrap_tail", alloc_tail, 0);
        cycle(1);
        for (int i = 1; i < 8; i++) do_wb(3'(i), 16'(i * 256), 3'(i), 1, BP_NORMAL);
        do_wb(3'd0, 16'h0F00, 3'd6, 1, BP_NORMAL);
        do_idle(10);
        chk("drain_empty", empty, 1);

        // Mispredict on the second entry flushes the younger two.
        do_reset();
        clog.delete();
        do_alloc(3'd4, 1); do_alloc(3'd5, 1); do_alloc(3'd6, 1); do_alloc(3'd7, 1);
        do_wb(3'd3, 16'h0D33, 3'd7, 1, BP_NORMAL);
        do_wb(3'd2, 16'h0C22, 3'd6, 1, BP_NORMAL);
        do_wb(3'd1, 16'h0B11, 3'd5, 1, BP_MISPRED);
        do_wb(3'd0, 16'h0A00, 3'd4, 1, BP_NORMAL);
        do_idle(6);
        chk("mp_count", clog.size(), 2);
        chk("mp_addr0", log_at(0).addr, 4); chk("mp_flush0", log_at(0).fl, 0);
        chk("mp_addr1", log_at(1).addr, 5); chk("mp_we1", log_at(1).we, 1);
        chk("mp_flush1", log_at(1).fl, 1);
        chk("mp_empty", empty, 1);
        chk("mp_tail", alloc_tail, 2);

        // Exception suppresses the register write but still flushes.
        clog.delete();
        do_alloc(3'd3, 1);
        do_wb(3'd2, 16'hBEEF, 3'd3, 1, BP_EXC);
        do_idle(2);
        chk("exc_count", clog.size(), 1);
        chk("exc_we", log_at(0).we, 0);
        chk("exc_flush", log_at(0).fl, 1);
        chk("exc_data", log_at(0).data, 16'hBEEF);

        // Dropped writebacks, then reset with work in flight.
        clog.delete();
        do_alloc(3'd1, 1); do_alloc(3'd2, 1);
        do_wb(3'd4, 16'h4444, 3'd2, 1, BP_NORMAL);
        do_wb(3'd4, 16'h9999, 3'd7, 1, BP_NORMAL);
        do_wb(3'd6, 16'hDEAD, 3'd5, 1, BP_NORMAL);
        do_wb(3'd3, 16'h3333, 3'd1, 1, BP_NORMAL);
        do_idle(3);
        chk("ill_count", clog.size(), 2);
        chk("ill_data0", log_at(0).data, 16'h3333);
        chk("ill_addr1", log_at(1).addr, 2);
        chk("ill_data1", log_at(1).data, 16'h4444);
        for (int i = 0; i < 5; i++) do_alloc(3'(i), 1);
        do_wb(3'd5, 16'h5555, 3'd0, 1, BP_NORMAL);
        clog.delete();
        do_reset();
        do_idle(4);
        chk("rst_mid_commits", clog.size(), 0);
        chk("rst_mid_empty", empty, 1);
        chk("rst_mid_tail", alloc_tail, 0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
                continue;
            end
            set_idle();
            alloc_req     = ($urandom_range(0, 9) < 6);
            alloc_destReg = 3'($urandom);
            alloc_we      = 1'($urandom);
            wb_valid      = ($urandom_range(0, 9) < 7);
            wb_result     = 16'($urandom);
            wb_destReg    = 3'($urandom);
            wb_we         = 1'($urandom);
            case ($urandom_range(0, 19))
                0:       wb_bp = 2'b01;
                1:       wb_bp = 2'b10;
                2:       wb_bp = 2'b11;
                default: wb_bp = 2'b00;
            endcase
            begin
                logic [2:0] pend[$];
                for (int i = 0; i < mq.size(); i++) if (!mq[i].done) pend.push_back(mq[i].idx);
                if (pend.size() > 0 && $urandom_range(0, 4) != 0)
                    wb_tail_rob = pend[$urandom_range(0, pend.size() - 1)];
                else
                    wb_tail_rob = 3'($urandom);
            end
            cycle(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
